// File: rtl/instr_loader.sv
// Boot-time instruction loader: byte stream with 16-bit word-count header,
// little-endian words written to instruction memory, core held in reset until done.
module instr_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           words_loaded
);

    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  core_rst_q, core_rst_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [15:0]           words_q, words_d;
    logic [15:0]           count_q, count_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [23:0]           buf_q, buf_d;

    logic        accept;
    logic [15:0] hdr_count;

    assign accept    = in_valid && in_ready_q;
    assign hdr_count = {in_data, count_q[7:0]};

    always_comb begin
        state_d    = state_q;
        in_ready_d = in_ready_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        core_rst_d = core_rst_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        words_d    = words_q;
        count_d    = count_q;
        byte_idx_d = byte_idx_q;
        buf_d      = buf_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_HDR0;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b1;
                    core_rst_d = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    words_d    = '0;
                end
            end
            S_HDR0: begin
                if (accept) begin
                    count_d[7:0] = in_data;
                    state_d      = S_HDR1;
                end
            end
            S_HDR1: begin
                if (accept) begin
                    count_d = hdr_count;
                    if (hdr_count == 16'd0) begin
                        state_d    = S_DONE;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b0;
                        core_rst_d = 1'b0;
                        done_d     = 1'b1;
                    end else if ({1'b0, hdr_count} > DEPTH) begin
                        state_d    = S_ERR;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b0;
                        error_d    = 1'b1;
                    end else begin
                        state_d    = S_DATA;
                        byte_idx_d = 2'd0;
                    end
                end
            end
            S_DATA: begin
                // in_ready low here means the final write is on the bus now
                if (!in_ready_q) begin
                    state_d    = S_DONE;
                    busy_d     = 1'b0;
                    core_rst_d = 1'b0;
                    done_d     = 1'b1;
                end else if (accept) begin
                    if (byte_idx_q == 2'd3) begin
                        we_d       = 1'b1;
                        addr_d     = words_q[ADDR_WIDTH-1:0];
                        wdata_d    = {in_data, buf_q};
                        words_d    = words_q + 16'd1;
                        byte_idx_d = 2'd0;
                        if (words_q + 16'd1 == count_q) begin
                            in_ready_d = 1'b0;
                        end
                    end else begin
                        buf_d      = {in_data, buf_q[23:8]};
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            words_q    <= '0;
            count_q    <= '0;
            byte_idx_q <= '0;
            buf_q      <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            core_rst_q <= core_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            words_q    <= words_d;
            count_q    <= count_d;
            byte_idx_q <= byte_idx_d;
            buf_q      <= buf_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign core_rst     = core_rst_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: image-level model feeds a write scoreboard,
// a negedge monitor checks every imem_we pulse for address, data and timing.
module tb_instr_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst;
    logic          busy;
    logic          done;
    logic          error;
    logic [15:0]   words_loaded;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            cyc;
    } wr_t;

    wr_t         sb[$];
    logic [31:0] img[$];

    instr_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .core_rst(core_rst),
        .busy(busy),
        .done(done),
        .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Each write must match the oldest outstanding word and appear in
    // the cycle right after its fourth byte was accepted.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_t e;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h",
                         imem_addr, imem_wdata);
            end else begin
                e = sb.pop_front();
                if (imem_addr !== e.addr || imem_wdata !== e.data ||
                    cyc != e.cyc) begin
                    fails++;
                    $display("FAIL write: got addr 0x%0h data 0x%0h cyc %0d expected addr 0x%0h data 0x%0h cyc %0d",
                             imem_addr, imem_wdata, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input int gap,
                             input bit poke, output int acc);
        int n;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
            chk("ready_in_gap", in_ready, 1);
        end
        in_valid = 1'b1;
        in_data  = b;
        start    = poke;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        if (n >= 50) chk("ready_timeout", 0, 1);
        @(posedge clk); #1;
        acc      = cyc;
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_core_rst", core_rst, 1);
        chk("start_done", done, 0);
        chk("start_error", error, 0);
        chk("start_words", words_loaded, 0);
        chk("start_ready", in_ready, 1);
    endtask

    task automatic push_exp(input int k, input int acc);
        wr_t e;
        e.addr = AW'(k);
        e.data = img[k];
        e.cyc  = acc;
        sb.push_back(e);
    endtask

    task automatic run_load(input int gmin, input int gmax, input int poke_at);
        int n;
        int acc;
        n = img.size();
        do_start();
        send_byte(8'(n), $urandom_range(gmax, gmin), 1'b0, acc);
        send_byte(8'(n >> 8), $urandom_range(gmax, gmin), 1'b0, acc);
        if (n == 0) begin
            chk("empty_done", done, 1);
            chk("empty_core_rst", core_rst, 0);
            chk("empty_busy", busy, 0);
            chk("empty_ready", in_ready, 0);
            chk("empty_words", words_loaded, 0);
            repeat (3) @(posedge clk);
            #1;
            return;
        end
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 4; j++) begin
                send_byte(8'(img[k] >> (8 * j)), $urandom_range(gmax, gmin),
                          (4 * k + j) == poke_at, acc);
                if (j == 3) push_exp(k, acc);
            end
        end
        chk("final_ready_low", in_ready, 0);
        chk("final_not_done", done, 0);
        @(posedge clk); #1;
        chk("load_done", done, 1);
        chk("load_core_rst", core_rst, 0);
        chk("load_busy", busy, 0);
        chk("load_ready", in_ready, 0);
        chk("load_words", words_loaded, 32'(n));
        chk("sb_drained", sb.size(), 0);
    endtask

    task automatic err_load(input logic [15:0] cnt);
        int acc;
        do_start();
        send_byte(cnt[7:0], 0, 1'b0, acc);
        send_byte(cnt[15:8], 0, 1'b0, acc);
        chk("err_error", error, 1);
        chk("err_core_rst", core_rst, 1);
        chk("err_ready", in_ready, 0);
        chk("err_busy", busy, 0);
        chk("err_done", done, 0);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("err_hold", error, 1);
        chk("err_words", words_loaded, 0);
    endtask

    task automatic scen2();
        img.delete();
        img.push_back(32'h00100093);
        img.push_back(32'h00200113);
    endtask

    task automatic rand_img(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back($urandom());
    endtask

    task automatic reset_midload();
        int acc;
        rand_img(3);
        do_start();
        send_byte(8'd3, 0, 1'b0, acc);
        send_byte(8'd0, 0, 1'b0, acc);
        for (int j = 0; j < 4; j++) send_byte(8'(img[0] >> (8 * j)), 0, 1'b0, acc);
        push_exp(0, acc);
        for (int j = 0; j < 3; j++) send_byte(8'(img[1] >> (8 * j)), 0, 1'b0, acc);
        in_valid = 1'b1;
        in_data  = 8'(img[1] >> 24);
        rst      = 1'b1;
        start    = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        chk("rst_we", imem_we, 0);
        chk("rst_core_rst", core_rst, 1);
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_words", words_loaded, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_idle_ready", in_ready, 0);
        chk("rst_sb", sb.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_core_rst", core_rst, 1);
        chk("reset_ready", in_ready, 0);
        chk("reset_we", imem_we, 0);
        chk("reset_done", done, 0);
        chk("reset_error", error, 0);
        chk("reset_words", words_loaded, 0);
        chk("reset_addr", imem_addr, 0);
        chk("reset_wdata", imem_wdata, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        scen2();
        run_load(0, 0, -1);
        run_load(3, 3, -1);

        img.delete();
        run_load(0, 0, -1);

        err_load(16'd257);
        scen2();
        run_load(0, 0, -1);

        reset_midload();
        rand_img(5);
        run_load(0, 1, 9);

        for (int t = 0; t < 6; t++) begin
            rand_img($urandom_range(10, 1));
            run_load(0, 2, -1);
        end

        rand_img(256);
        run_load(0, 0, -1);
        err_load(16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Boot-time instruction loader placed directly upstream of the rv32i pipeline core (microprocessor).
- Accepts a byte stream (valid/ready) carrying a 16-bit word-count header followed by little-endian 32-bit instructions.
- Writes each word into the core's instruction memory and holds the core in reset until the image is completely loaded.
- Replaces hand-forced instruction words in benches; also usable as an on-chip bootloader front end.

Parameters:
ADDR_WIDTH, 8, instruction-memory word-address width; DEPTH = 2**ADDR_WIDTH words.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR
in_valid  input  1  byte-stream valid
in_data  input  8  byte-stream data
in_ready  output  1  loader can accept a byte this cycle
imem_we  output  1  instruction-memory write strobe, one cycle per word
imem_addr  output  ADDR_WIDTH  word address of the write
imem_wdata  output  32  assembled instruction word
core_rst  output  1  active-high reset to the core; low only while a valid image is loaded
busy  output  1  load in progress (HDR0, HDR1 or DATA)
done  output  1  image loaded successfully
error  output  1  header word count exceeds DEPTH
words_loaded  output  16  words written in the current or last load

Behaviour:
- One clock: clk. Reset is synchronous, active-high, named rst. All outputs are registered.
- Reset values: state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, busy=0, done=0, error=0, words_loaded=0.
- A byte is accepted only on a cycle where in_valid && in_ready. When in_ready=0, in_data is ignored and not consumed.
- States: IDLE, HDR0, HDR1, DATA, DONE, ERR.
- IDLE: in_ready=0. On start, go to HDR0 and set busy=1, core_rst=1, done=0, error=0, words_loaded=0.
- HDR0: in_ready=1. Accepted byte becomes count[7:0]; go to HDR1.
- HDR1: in_ready=1. Accepted byte becomes count[15:8].
  - count==0: go to DONE.
  - count>DEPTH: go to ERR.
  - Otherwise: go to DATA with byte_idx=0 and word_idx=0.
- DATA assembly: little-endian. Byte k of a word (k=0..3) goes to bits [8k+7:8k].
- DATA write: if the 4th byte is accepted at cycle T, then at T+1 imem_we=1 for exactly one cycle, with imem_addr=word_idx and imem_wdata=the assembled word. words_loaded increments at that same T+1 edge, and word_idx advances.
- DATA throughput: in_ready stays 1 during non-final writes, so back-to-back bytes run at 1 byte/cycle with no bubbles. in_ready drops to 0 on the cycle after the final byte of the final word is accepted.
- Final write: if it occurs at cycle W, then at W+1 the state is DONE.
- DONE: done=1, busy=0, core_rst=0, in_ready=0, imem_we=0.
- ERR: error=1, busy=0, core_rst=1, in_ready=0. No memory writes occur for that load.
- A start in DONE or ERR restarts the load (HDR0). core_rst rises again on the same edge that leaves DONE.
- start while busy=1 is ignored.
- Zero-count, HDR1 byte accepted at T: done=1 and core_rst=0 at T+1. No imem_we.
- Overflow check compares count against DEPTH (e.g. 256 for ADDR_WIDTH=8). count==DEPTH is legal; the last address is DEPTH-1 and imem_addr never wraps.
- rst mid-load: the next edge restores all reset values. Any partial word is discarded, and no write is issued on or after the reset edge.
- rst and start together: rst wins.
- imem_addr and imem_wdata hold their last values when imem_we=0.

Test Plan:
1. Reset: rst=1 for 2 cycles -> core_rst=1, in_ready=0, imem_we=0, done=0, error=0, words_loaded=0.
2. Back-to-back load: start, then bytes 02 00 93 00 10 00 13 01 20 00 with in_valid held high -> imem_we@addr0=0x00100093, imem_we@addr1=0x00200113, each one cycle after its 4th byte. done=1 and core_rst=0 one cycle after the 2nd write; words_loaded=2.
3. Gapped stream: same image with in_valid low for 3 cycles between every byte -> identical writes and data, no extra imem_we pulses; in_ready stays 1 through the gaps.
4. Empty image: header 00 00 -> done=1 and core_rst=0 one cycle after the 2nd header byte; imem_we never asserts.
5. Overflow: header 01 01 (257) with ADDR_WIDTH=8 -> error=1, core_rst=1, in_ready=0, no writes. Then start plus the scenario 2 stream -> error=0, successful load.
6. Interruptions:
   - rst mid-load: rst=1 after 2 data bytes of word 0 -> no imem_we, IDLE, core_rst=1, words_loaded=0.
   - start while busy: start pulse mid-DATA -> ignored, load completes normally.
